// File: rtl/csd_mult_sequencer.sv
// csd_mult_sequencer: computes a*b for one requester by splitting the N-bit
// multiplier b into signed power-of-two terms and issuing them, two at a time,
// to a shared two-term shift-add multiplier; partial products are accumulated.
//
// Optional feature macro: CSD_MULT_SEQ_RECODE_EN
//   defined   - b is recoded to canonical signed digits (fewer terms, +/-)
//   undefined - terms are the plain set bits of b, all positive
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_vld/req_rdy/req_a/req_b  request handshake and operands
//   rsp_vld/rsp_rdy/rsp_c        result handshake and product
//   mul_vld, mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign
//                                operation issued to the shared multiplier
//   mul_c, mul_result_vld        multiplier result and its strobe
module csd_mult_sequencer #(
  parameter int unsigned a_N = 16,
  parameter int unsigned N   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [a_N-1:0]     req_a,
  input  logic [N-1:0]       req_b,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [2*a_N-1:0]   rsp_c,
  output logic               mul_vld,
  output logic [a_N-1:0]     mul_a,
  output logic [N-1:0]       mul_b_i,
  output logic [N-1:0]       mul_b_j,
  output logic               mul_one_term,
  output logic               mul_b_sign,
  input  logic [2*a_N-1:0]   mul_c,
  input  logic               mul_result_vld
);

  localparam int unsigned CW = 2 * a_N;
  localparam int unsigned DW = N + 1;

  typedef enum logic [2:0] {IDLE, RECODE, ISSUE, WAIT, ACC, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    b_q, b_d;
  logic [DW-1:0]   pos_q, pos_d, neg_q, neg_d;
  logic [CW-1:0]   acc_q, acc_d, mulc_q, mulc_d;
`ifdef CSD_MULT_SEQ_RECODE_EN
  logic            sub_q, sub_d;
`endif

  logic            req_rdy_d, rsp_vld_d, mul_vld_d, mul_one_term_d, mul_b_sign_d;
  logic [CW-1:0]   rsp_c_d;
  logic [a_N-1:0]  mul_a_d;
  logic [N-1:0]    mul_b_i_d, mul_b_j_d;
  logic            start_issue;

  // Digit masks of b: rec_pos marks +1 digits, rec_neg marks -1 digits
  logic [DW-1:0]   rec_pos, rec_neg;
`ifdef CSD_MULT_SEQ_RECODE_EN
  logic [DW-1:0]   xh, x3, xc;
  // Non-adjacent form: 1.5*b against b/2 exposes where runs of ones collapse
  always_comb begin
    xh      = DW'(b_q >> 1);
    x3      = DW'(b_q) + xh;
    xc      = xh ^ x3;
    rec_pos = x3 & xc;
    rec_neg = xh & xc;
  end
`else
  always_comb begin
    rec_pos = DW'(b_q);
    rec_neg = '0;
  end
`endif

  // Term source: freshly recoded masks in RECODE, remaining masks otherwise
  logic [DW-1:0]   src_pos, src_neg, src_all, rem_pos, rem_neg;
  logic            have_p, have_q, p_neg, q_neg;
  logic [N-1:0]    p_idx, q_idx;

  // Pop the two most significant remaining terms
  always_comb begin
    src_pos = (state_q == RECODE) ? rec_pos : pos_q;
    src_neg = (state_q == RECODE) ? rec_neg : neg_q;
    src_all = src_pos | src_neg;
    rem_pos = src_pos;
    rem_neg = src_neg;
    have_p  = 1'b0;
    have_q  = 1'b0;
    p_neg   = 1'b0;
    q_neg   = 1'b0;
    p_idx   = '0;
    q_idx   = '0;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      if (src_all[i]) begin
        if (!have_p) begin
          have_p     = 1'b1;
          p_idx      = N'(i);
          p_neg      = src_neg[i];
          rem_pos[i] = 1'b0;
          rem_neg[i] = 1'b0;
        end else if (!have_q) begin
          have_q     = 1'b1;
          q_idx      = N'(i);
          q_neg      = src_neg[i];
          rem_pos[i] = 1'b0;
          rem_neg[i] = 1'b0;
        end
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d        = state_q;
    b_d            = b_q;
    pos_d          = pos_q;
    neg_d          = neg_q;
    acc_d          = acc_q;
    mulc_d         = mulc_q;
`ifdef CSD_MULT_SEQ_RECODE_EN
    sub_d          = sub_q;
`endif
    req_rdy_d      = 1'b0;
    rsp_vld_d      = 1'b0;
    rsp_c_d        = '0;
    mul_vld_d      = 1'b0;
    mul_a_d        = mul_a;
    mul_b_i_d      = mul_b_i;
    mul_b_j_d      = mul_b_j;
    mul_one_term_d = mul_one_term;
    mul_b_sign_d   = mul_b_sign;
    start_issue    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          state_d = RECODE;
          mul_a_d = req_a;
          b_d     = req_b;
          acc_d   = '0;
        end
      end
      RECODE: start_issue = 1'b1;
      ISSUE: begin
        state_d   = WAIT;
        mul_vld_d = 1'b1;
      end
      WAIT: begin
        if (mul_result_vld) begin
          mulc_d  = mul_c;
          state_d = ACC;
        end else begin
          mul_vld_d = 1'b1;
        end
      end
      ACC: begin
`ifdef CSD_MULT_SEQ_RECODE_EN
        acc_d = sub_q ? (acc_q - mulc_q) : (acc_q + mulc_q);
`else
        acc_d = acc_q + mulc_q;
`endif
        start_issue = 1'b1;
      end
      DONE: begin
        if (rsp_rdy) begin
          state_d = IDLE;
        end else begin
          rsp_vld_d = 1'b1;
          rsp_c_d   = rsp_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // A negative leading term flips the whole pair into a subtraction
    if (start_issue) begin
      if (have_p) begin
        state_d        = ISSUE;
        mul_vld_d      = 1'b1;
        mul_b_i_d      = p_idx;
        mul_b_j_d      = have_q ? q_idx : '0;
        mul_one_term_d = !have_q;
        mul_b_sign_d   = have_q && (p_neg != q_neg);
        pos_d          = rem_pos;
        neg_d          = rem_neg;
`ifdef CSD_MULT_SEQ_RECODE_EN
        sub_d          = p_neg;
`endif
      end else begin
        state_d   = DONE;
        rsp_vld_d = 1'b1;
        rsp_c_d   = acc_d;
      end
    end

    req_rdy_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      b_q          <= '0;
      pos_q        <= '0;
      neg_q        <= '0;
      acc_q        <= '0;
      mulc_q       <= '0;
`ifdef CSD_MULT_SEQ_RECODE_EN
      sub_q        <= 1'b0;
`endif
      req_rdy      <= 1'b1;
      rsp_vld      <= 1'b0;
      rsp_c        <= '0;
      mul_vld      <= 1'b0;
      mul_a        <= '0;
      mul_b_i      <= '0;
      mul_b_j      <= '0;
      mul_one_term <= 1'b0;
      mul_b_sign   <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      pos_q        <= pos_d;
      neg_q        <= neg_d;
      acc_q        <= acc_d;
      mulc_q       <= mulc_d;
`ifdef CSD_MULT_SEQ_RECODE_EN
      sub_q        <= sub_d;
`endif
      req_rdy      <= req_rdy_d;
      rsp_vld      <= rsp_vld_d;
      rsp_c        <= rsp_c_d;
      mul_vld      <= mul_vld_d;
      mul_a        <= mul_a_d;
      mul_b_i      <= mul_b_i_d;
      mul_b_j      <= mul_b_j_d;
      mul_one_term <= mul_one_term_d;
      mul_b_sign   <= mul_b_sign_d;
    end
  end

endmodule

// File: tb/tb_csd_mult_sequencer.sv
// Testbench for csd_mult_sequencer (a_N=16, N=4) with a latency-3 multiplier
// model. The reference derives the term list from b arithmetically and the
// expected cycle timeline from the op count; results are checked against a*b.
module tb_csd_mult_sequencer;

  localparam int L = 3;

`ifdef CSD_MULT_SEQ_RECODE_EN
  localparam int LAT15   = 7;
  localparam int NOPS15  = 1;
  localparam int OP15_BI = 4, OP15_BJ = 0, OP15_SG = 1;
  localparam int OP11_BI = 4, OP11_BJ = 2, OP11_SG = 1;
`else
  localparam int LAT15   = 12;
  localparam int NOPS15  = 2;
  localparam int OP15_BI = 3, OP15_BJ = 2, OP15_SG = 0;
  localparam int OP11_BI = 3, OP11_BJ = 1, OP11_SG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [15:0] req_a;
  logic [3:0]  req_b;
  logic [31:0] rsp_c;
  logic        mul_vld, mul_one_term, mul_b_sign, mul_result_vld;
  logic [15:0] mul_a;
  logic [3:0]  mul_b_i, mul_b_j;
  logic [31:0] mul_c;

  // Multiplier model outputs plus a separate spurious-strobe injector
  bit          mdl_rv = 1'b0;
  logic [31:0] mdl_c  = '0;
  bit          inj    = 1'b0;
  logic [31:0] inj_c  = '0;
  assign mul_result_vld = mdl_rv | inj;
  assign mul_c          = inj ? inj_c : mdl_c;

  csd_mult_sequencer #(.a_N(16), .N(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_c(rsp_c),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b_i(mul_b_i), .mul_b_j(mul_b_j),
    .mul_one_term(mul_one_term), .mul_b_sign(mul_b_sign),
    .mul_c(mul_c), .mul_result_vld(mul_result_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference term list: digits of b, MSB first, paired into operations
  typedef struct { int bi; int bj; bit one; bit sgn; } op_t;
  op_t exp_ops[$];

  function automatic void build_ops(input int b);
    int   d[5];
    int   x;
    int   tp[$];
    int   ts[$];
    op_t  o;
    exp_ops.delete();
    x = b;
    for (int i = 0; i < 5; i++) begin
`ifdef CSD_MULT_SEQ_RECODE_EN
      if (x % 2 != 0) begin
        d[i] = 2 - (x % 4);
        x    = (x - d[i]) / 2;
      end else begin
        d[i] = 0;
        x    = x / 2;
      end
`else
      d[i] = (x >> i) & 1;
`endif
    end
    for (int i = 4; i >= 0; i--) begin
      if (d[i] != 0) begin
        tp.push_back(i);
        ts.push_back(d[i]);
      end
    end
    for (int k = 0; k < tp.size(); k += 2) begin
      o.bi = tp[k];
      if (k + 1 < tp.size()) begin
        o.one = 1'b0;
        o.bj  = tp[k+1];
        o.sgn = (ts[k] != ts[k+1]);
      end else begin
        o.one = 1'b1;
        o.bj  = 0;
        o.sgn = 1'b0;
      end
      exp_ops.push_back(o);
    end
  endfunction

  // Multiplier model: answers L cycles after each mul_vld rise
  logic prev_mv = 1'b0;
  bit   pend    = 1'b0;
  int   fire, pa, val;
  always @(negedge clk) begin
    mdl_rv = 1'b0;
    if (mul_vld && !prev_mv) begin
      pend = 1'b1;
      fire = cyc + L;
      pa   = int'(mul_a);
      if (mul_one_term)    val = 1 << int'(mul_b_i);
      else if (mul_b_sign) val = (1 << int'(mul_b_i)) - (1 << int'(mul_b_j));
      else                 val = (1 << int'(mul_b_i)) + (1 << int'(mul_b_j));
    end
    prev_mv = mul_vld;
    if (pend && cyc == fire) begin
      mdl_rv = 1'b1;
      mdl_c  = 32'(pa * val);
      pend   = 1'b0;
    end
  end

  // Compare process: every cycle against the reference timeline
  bit   busy = 1'b0;
  int   t0, rsp_at, rel, k, ph, ea, eprod;
  bit   emv, erv;
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      chk("rst_req_rdy", int'(req_rdy), 1);
      chk("rst_rsp_vld", int'(rsp_vld), 0);
      chk("rst_mul_vld", int'(mul_vld), 0);
      chk("rst_rsp_c", int'(rsp_c), 0);
    end else if (!busy) begin
      chk("idle_req_rdy", int'(req_rdy), 1);
      chk("idle_rsp_vld", int'(rsp_vld), 0);
      chk("idle_mul_vld", int'(mul_vld), 0);
      if (req_vld) begin
        busy   = 1'b1;
        t0     = cyc;
        ea     = int'(req_a);
        eprod  = int'(req_a) * int'(req_b);
        build_ops(int'(req_b));
        rsp_at = t0 + 2 + exp_ops.size() * (L + 2);
      end
    end else begin
      rel = cyc - t0 - 2;
      emv = 1'b0;
      k   = 0;
      if (rel >= 0) begin
        k   = rel / (L + 2);
        ph  = rel % (L + 2);
        emv = (k < exp_ops.size()) && (ph <= L);
      end
      erv = (cyc >= rsp_at);
      chk("busy_req_rdy", int'(req_rdy), 0);
      chk("mul_vld", int'(mul_vld), int'(emv));
      chk("rsp_vld", int'(rsp_vld), int'(erv));
      if (emv) begin
        chk("mul_a", int'(mul_a), ea);
        chk("mul_one_term", int'(mul_one_term), int'(exp_ops[k].one));
        chk("mul_b_i", int'(mul_b_i), exp_ops[k].bi);
        if (!exp_ops[k].one) begin
          chk("mul_b_j", int'(mul_b_j), exp_ops[k].bj);
          chk("mul_b_sign", int'(mul_b_sign), int'(exp_ops[k].sgn));
        end
      end
      if (erv) begin
        chk("rsp_c", int'(rsp_c), eprod);
        if (rsp_rdy) busy = 1'b0;
      end
    end
  end

  // Captured issue fields of the most recent request
  int cap_bi[8], cap_bj[8], cap_one[8], cap_sg[8];
  int ncap;

  task automatic run_req(input logic [15:0] a, input logic [3:0] b, input int hold,
                         input bit spur, output int got, output int lat);
    int   t;
    logic prev;
    req_a = a; req_b = b; req_vld = 1'b1;
    t = cyc; ncap = 0; lat = -1; got = 0; prev = 1'b0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      if (mul_vld && !prev && ncap < 8) begin
        cap_bi[ncap]  = int'(mul_b_i);
        cap_bj[ncap]  = int'(mul_b_j);
        cap_one[ncap] = int'(mul_one_term);
        cap_sg[ncap]  = int'(mul_b_sign);
        ncap++;
      end
      prev = mul_vld;
      if (rsp_vld) begin
        lat = cyc - t;
        got = int'(rsp_c);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (lat < 0) begin
      chk("rsp_seen", int'(rsp_vld), 1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      inj   = spur && (h == 1);
      inj_c = $urandom;
      @(posedge clk); #1;
    end
    inj = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
  endtask

  task automatic idle_spur();
    inj = 1'b1; inj_c = $urandom;
    @(posedge clk); #1;
    inj = 1'b0;
    @(posedge clk); #1;
  endtask

  int got, lat;

  initial begin
    rst = 1'b1; req_vld = 1'b1; req_a = 16'd100; req_b = 4'd15; rsp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // a=100, b=15 accepted in the first cycle after reset release
    run_req(16'd100, 4'd15, 0, 1'b0, got, lat);
    chk("b15_rsp_c", got, 1500);
    chk("b15_latency", lat, LAT15);
    chk("b15_nops", ncap, NOPS15);
    chk("b15_op0_bi", cap_bi[0], OP15_BI);
    chk("b15_op0_bj", cap_bj[0], OP15_BJ);
    chk("b15_op0_sign", cap_sg[0], OP15_SG);
    chk("b15_op0_one", cap_one[0], 0);

    // a=7, b=11: a two-term op then a single term at bit 0
    run_req(16'd7, 4'd11, 1, 1'b0, got, lat);
    chk("b11_rsp_c", got, 77);
    chk("b11_latency", lat, 12);
    chk("b11_nops", ncap, 2);
    chk("b11_op0_bi", cap_bi[0], OP11_BI);
    chk("b11_op0_bj", cap_bj[0], OP11_BJ);
    chk("b11_op0_sign", cap_sg[0], OP11_SG);
    chk("b11_op1_one", cap_one[1], 1);
    chk("b11_op1_bi", cap_bi[1], 0);

    // b=0: no multiplier traffic, immediate zero result
    idle_spur();
    run_req(16'hFFFF, 4'd0, 0, 1'b0, got, lat);
    chk("b0_rsp_c", got, 0);
    chk("b0_latency", lat, 2);
    chk("b0_nops", ncap, 0);

    // Largest operands, result held 5 cycles with a spurious strobe in DONE
    run_req(16'hFFFF, 4'd15, 5, 1'b1, got, lat);
    chk("max_rsp_c", got, 983025);
    chk("max_latency", lat, LAT15);
    idle_spur();

    // Reset while waiting on the multiplier; its late strobe must be ignored
    req_a = 16'd9; req_b = 4'd13; req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_req_rdy", int'(req_rdy), 1);
    run_req(16'd3, 4'd5, 0, 1'b0, got, lat);
    chk("after_rst_rsp_c", got, 15);

    // Randomized traffic checked by the compare process
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_spur();
      run_req(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/csd_mult_sequencer.md
# csd_mult_sequencer

Sequences a full N-bit unsigned multiplier operand through the shared two-term shift-add multiplier (`b = 2^i ± 2^j` per operation). The block recodes `b` into signed power-of-two digits and issues them in pairs. It accumulates the partial products and returns `a*b` to a single requester over a valid/ready handshake. It sits between the requesting datapath and one multiplier instance, and is the only master of that multiplier.

## Interface
Parameters:
- `a_N`, 16, width of operand `a`; must satisfy `a_N >= N+1`.
- `N`, 4, width of operand `b`, and width of the multiplier's `b_i`/`b_j` shift fields.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  high only in IDLE.
- `req_a`  in  a_N  multiplicand, unsigned.
- `req_b`  in  N  multiplier, unsigned.
- `rsp_vld`  out  1  result valid; held until `rsp_rdy`.
- `rsp_rdy`  in  1  requester accepts result.
- `rsp_c`  out  2*a_N  product `req_a*req_b`.
- `mul_vld`  out  1  drives the multiplier's `vld`.
- `mul_a`  out  a_N  drives the multiplier's `a`.
- `mul_b_i`, `mul_b_j`  out  N  term shift amounts.
- `mul_one_term`  out  1  high means single term `2^b_i`.
- `mul_b_sign`  out  1  high means `2^i - 2^j`; low means `2^i + 2^j`.
- `mul_c`  in  2*a_N  multiplier result.
- `mul_result_vld`  in  1  multiplier result strobe.

## Operation
- FSM states: IDLE, RECODE, ISSUE, WAIT, ACC, DONE.
- IDLE: `req_rdy=1`. On `req_vld`, latch `req_a` and `req_b`, then go to RECODE.
- RECODE (1 cycle): convert `b` to CSD digits d[N:0] ∈ {-1,0,+1}. Build a term list ordered from MSB to LSB and set the term count K. K=0 goes to DONE with `acc=0`; otherwise go to ISSUE.
- ISSUE: pop up to two terms, (p, sp) then (q, sq) with p>q. Drive outputs as follows:
  - Two terms, sp=+, sq=+: `b_i=p`, `b_j=q`, `sign=0`, add.
  - Two terms, sp=+, sq=−: `b_i=p`, `b_j=q`, `sign=1`, add.
  - Two terms, sp=−, sq=+: `b_i=p`, `b_j=q`, `sign=1`, subtract.
  - Two terms, sp=−, sq=−: `b_i=p`, `b_j=q`, `sign=0`, subtract.
  - One term left: `one_term=1`, `b_i=p`, add if + and subtract if −.
  - Raise `mul_vld` and go to WAIT.
- WAIT: hold all `mul_*` outputs stable with `mul_vld=1` until `mul_result_vld`. In that cycle, register `mul_c` and go to ACC.
- ACC: `mul_vld=0`. Compute `acc ± captured mul_c` modulo `2^(2*a_N)`. Intermediate values may wrap; the final value is exact because `a*b < 2^(a_N+N)`. Go to ISSUE if terms remain, else DONE.
- DONE: `rsp_vld=1` and `rsp_c=acc`. On `rsp_rdy`, go to IDLE.
- `mul_result_vld` outside WAIT is ignored.
- Reset values: all outputs 0 except `req_rdy=1`; `acc=0`; state IDLE.
- Reset mid-operation:
  - Abort immediately and drop `mul_vld`.
  - Discard the accumulator.
  - A late `mul_result_vld` after reset is ignored.

## Timing
- Request accepted at cycle T: RECODE at T+1, first `mul_vld` at T+2.
- Per operation:
  - `mul_vld` is high from issue until the cycle `mul_result_vld` is sampled.
  - `mul_vld` is low for exactly 1 cycle (ACC) before the next issue.
- Latency with ops = ceil(K/2) and multiplier latency L (cycles from `mul_vld` rising to `mul_result_vld`): `rsp_vld` rises at T + 2 + ops*(L+2). For K=0, `rsp_vld` rises at T+2.
- Back-to-back: the next request is accepted the cycle after the `rsp_vld`&`rsp_rdy` handshake (IDLE is one cycle minimum).

## Configuration
- `CSD_MULT_SEQ_RECODE_EN` defined: CSD recoding as above, at most ceil((N+1)/2) nonzero digits.
- `CSD_MULT_SEQ_RECODE_EN` undefined:
  - Terms are the plain set bits of `b`, all positive.
  - `mul_b_sign` is always 0 and no subtract path exists.
  - Same FSM and handshakes.

## Test plan
(N=4, a_N=16, multiplier model with L=3)
- Reset with `req_vld=1` → `req_rdy=1`, `rsp_vld=0`, `mul_vld=0`. After reset release the request is accepted next cycle.
- a=100, b=15, RECODE_EN → one op: `b_i=4`, `b_j=0`, `sign=1`; `rsp_c=1500` at T+7. Without the macro → two ops (8+4, 2+1); `rsp_c=1500` at T+12.
- a=7, b=11, RECODE_EN → op1 `b_i=4`, `b_j=2`, `sign=1`, add. Op2 `one_term`, `b_i=0`, subtract. `rsp_c=77`.
- a=65535, b=0 → no `mul_vld` pulse; `rsp_c=0` at T+2. Then a=65535, b=15 → `rsp_c=983025`.
- Hold `rsp_rdy=0` for 5 cycles → `rsp_vld` and `rsp_c` stay stable and `req_rdy=0`. Inject spurious `mul_result_vld` in IDLE/DONE → no effect.
- Assert `rst` during WAIT of a=9, b=13 → `mul_vld` drops the same cycle and a late `mul_result_vld` is ignored. The next request a=3, b=5 returns 15.
